// File: rtl/ila_checker.sv
// RX-side checker for the JESD204B initial lane alignment sequence.
// Captures the link configuration and flags sequence end or a coded error.
module ila_checker #(
   parameter int NUM_MF = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [7:0]   i_F,
   input  logic [4:0]   i_K,
   input  logic [7:0]   i_data,
   input  logic         i_k,
   input  logic         i_vld,
   output logic [111:0] o_cfg,
   output logic         o_cfg_vld,
   output logic         o_seq_end,
   output logic         o_err,
   output logic [2:0]   o_err_code,
   output logic         o_busy
);

   typedef enum logic [2:0] {IDLE, WAIT_R, MF, DONE, ERR} state_t;

   localparam logic [7:0] K_R     = 8'h1C;
   localparam logic [7:0] K_A     = 8'h7C;
   localparam logic [7:0] K_Q     = 8'h9C;
   localparam logic [7:0] K_K     = 8'hBC;
   localparam logic [7:0] MF_LAST = 8'(NUM_MF - 1);

   state_t        state, state_n;
   logic [12:0]   oct, last;
   logic [7:0]    mf, acc;
   logic [8:0]    f1;
   logic [5:0]    k1;
   logic [13:0]   len_c;
   logic [3:0]    idx;
   logic [2:0]    code_n;
   logic          ld_err, step, do_acc, do_cap, fchk_ok;

   assign f1     = {1'b0, i_F} + 9'd1;
   assign k1     = {1'b0, i_K} + 6'd1;
   assign len_c  = 14'(f1) * 14'(k1);
   assign idx    = 4'(oct[3:0] - 4'd2);
   assign o_busy = (state == WAIT_R) || (state == MF);

   // Value contributed to FCHK by config octet idx (reserved bits excluded)
   function automatic logic [7:0] fsum(input logic [3:0] n, input logic [7:0] d);
      logic [7:0] lo5;
      lo5 = {3'd0, d[4:0]};
      case (n)
         4'd0, 4'd4, 4'd6: fsum = d;
         4'd1:             fsum = {4'd0, d[7:4]} + {4'd0, d[3:0]};
         4'd2:             fsum = {7'd0, d[6]} + {7'd0, d[5]} + lo5;
         4'd3, 4'd10:      fsum = {7'd0, d[7]} + lo5;
         4'd5:             fsum = lo5;
         4'd7:             fsum = {6'd0, d[7:6]} + lo5;
         4'd8, 4'd9:       fsum = {5'd0, d[7:5]} + lo5;
         default:          fsum = 8'd0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      ld_err  = 1'b0;
      code_n  = 3'd0;
      step    = 1'b0;
      do_acc  = 1'b0;
      do_cap  = 1'b0;
      fchk_ok = 1'b0;
      if (i_start) begin
         if (len_c < 14'd17) begin
            state_n = ERR;
            ld_err  = 1'b1;
            code_n  = 3'd7;
         end else begin
            state_n = WAIT_R;
         end
      end else if (i_vld) begin
         case (state)
            WAIT_R: begin
               if (i_k && i_data == K_R) begin
                  state_n = MF;
                  step    = 1'b1;
               end else if (!(i_k && i_data == K_K)) begin
                  state_n = ERR;
                  ld_err  = 1'b1;
                  code_n  = 3'd1;
               end
            end
            MF: begin
               unique case (1'b1)
                  oct == 13'd0:
                     if (!(i_k && i_data == K_R)) code_n = 3'd2;
                  oct == last:
                     if (!(i_k && i_data == K_A)) code_n = 3'd3;
                  (mf == 8'd1) && (oct == 13'd1):
                     if (!(i_k && i_data == K_Q)) code_n = 3'd4;
                  default:
                     if (i_k) code_n = 3'd5;
               endcase
               if (mf == 8'd1 && oct >= 13'd2 && oct <= 13'd15)
                  do_cap = 1'b1;
               if (mf == 8'd1 && oct >= 13'd2 && oct <= 13'd12)
                  do_acc = 1'b1;
               if (code_n == 3'd0 && mf == 8'd1 && oct == 13'd15) begin
                  if (i_data != acc) code_n = 3'd6;
                  else               fchk_ok = 1'b1;
               end
               if (code_n != 3'd0) begin
                  state_n = ERR;
                  ld_err  = 1'b1;
               end else begin
                  step = 1'b1;
                  if (oct == last && mf == MF_LAST) state_n = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oct        <= '0;
         last       <= '0;
         mf         <= '0;
         acc        <= '0;
         o_cfg      <= '0;
         o_cfg_vld  <= 1'b0;
         o_seq_end  <= 1'b0;
         o_err      <= 1'b0;
         o_err_code <= 3'd0;
      end else begin
         o_seq_end <= 1'b0;
         if (i_start) begin
            oct        <= '0;
            mf         <= '0;
            acc        <= '0;
            last       <= 13'(len_c - 14'd1);
            o_cfg_vld  <= 1'b0;
            o_err      <= ld_err;
            o_err_code <= code_n;
         end else begin
            if (ld_err) begin
               o_err      <= 1'b1;
               o_err_code <= code_n;
            end
            if (step) begin
               if (oct == last) begin
                  oct <= '0;
                  mf  <= mf + 8'd1;
               end else begin
                  oct <= oct + 13'd1;
               end
            end
            if (do_cap)  o_cfg[{idx, 3'b000} +: 8] <= i_data;
            if (do_acc)  acc <= acc + fsum(idx, i_data);
            if (fchk_ok) o_cfg_vld <= 1'b1;
            if (step && state_n == DONE) o_seq_end <= 1'b1;
         end
      end
   end

endmodule
